// File: rtl/grid_overlay_renderer_pkg.sv
// grid_overlay_pkg: shared types, default colours and index-width helpers for the grid overlay.
package grid_overlay_pkg;
    typedef enum logic [1:0] {IDLE, FLASH, DONE} flash_state_t;
    localparam logic [7:0] DEF_MOVE_COLOR  = 8'hAA;
    localparam logic [7:0] DEF_BACK_COLOR  = 8'h55;
    localparam logic [7:0] DEF_FLASH_COLOR = 8'hFF;
    localparam logic [7:0] DEF_LINE_COLOR  = 8'h11;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int cell_idx_w(input int cols, input int rows);
        return idx_w(cols * rows);
    endfunction
endpackage

// File: rtl/grid_overlay_renderer_scan_tracker.sv
// scan_tracker: follows the row-major pixel address with incremental x/y/cell counters (no divide).
// Under GRID_LINES_EN it also flags the first pixel row/column of each cell.
module scan_tracker
    import grid_overlay_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CELL_W = 40,
    parameter int CELL_H = 40,
    parameter int COLS = 12,
    parameter int ROWS = 12,
    parameter int X_OFF = 0
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    output logic [idx_w(COLS)-1:0]   cx,
    output logic [idx_w(ROWS)-1:0]   cy,
    output logic                     in_grid,
    output logic                     locked,
    output logic                     frame_start,
`ifdef GRID_LINES_EN
    output logic                     on_line,
`endif
    output logic                     sync_err
);
    localparam int XW = idx_w(H_RES), YW = idx_w(V_RES + 1);
    localparam int SXW = idx_w(CELL_W), SYW = idx_w(CELL_H);
    localparam int GW = COLS * CELL_W, GH = ROWS * CELL_H;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(H_RES * V_RES - 1);

    logic [ADDR_W-1:0] prev_addr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SXW-1:0] sub_x;
    logic [SYW-1:0] sub_y;
    logic hold, step, eol;

    // A repeated address while locked is a blanking stall, even at address 0.
    assign hold = locked && address == prev_addr;
    assign frame_start = !hold && address == '0;
    assign step = locked && {1'b0, address} == {1'b0, prev_addr} + 1'b1 && {1'b0, address} <= LAST;
    assign eol = x == XW'(H_RES - 1);
    assign in_grid = int'(x) >= X_OFF && int'(x) < X_OFF + GW && int'(y) < GH;
`ifdef GRID_LINES_EN
    assign on_line = sub_x == '0 || sub_y == '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_addr <= '0;
            locked <= 1'b0;
            sync_err <= 1'b0;
            x <= '0;
            y <= '0;
            sub_x <= '0;
            sub_y <= '0;
            cx <= '0;
            cy <= '0;
        end else begin
            prev_addr <= address;
            sync_err <= 1'b0;
            if (frame_start) begin
                locked <= 1'b1;
                x <= '0;
                y <= '0;
                sub_x <= '0;
                sub_y <= '0;
                cx <= '0;
                cy <= '0;
            end else if (step) begin
                x <= eol ? '0 : x + 1'b1;
                if (eol) begin
                    y <= y + 1'b1;
                    sub_x <= '0;
                    cx <= '0;
                    if (int'(y) < GH - 1) begin
                        sub_y <= sub_y == SYW'(CELL_H - 1) ? '0 : sub_y + 1'b1;
                        if (sub_y == SYW'(CELL_H - 1)) cy <= cy + 1'b1;
                    end
                end else if (int'(x) >= X_OFF && int'(x) < X_OFF + GW - 1) begin
                    sub_x <= sub_x == SXW'(CELL_W - 1) ? '0 : sub_x + 1'b1;
                    if (sub_x == SXW'(CELL_W - 1)) cx <= cx + 1'b1;
                end
            end else if (locked && !hold) begin
                locked <= 1'b0;
                sync_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/grid_overlay_renderer.sv
// grid_overlay_renderer: inline VGA overlay painting occupied grid cells and row-clear flashes, 2-cycle pipeline.
// Define GRID_LINES_EN to draw cell borders in LINE_COLOR.
module grid_overlay_renderer
    import grid_overlay_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int PIX_W = 8,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CELL_W = 40,
    parameter int CELL_H = 40,
    parameter int COLS = 12,
    parameter int ROWS = 12,
    parameter int X_OFF = 0,
    parameter logic [PIX_W-1:0] MOVE_COLOR = PIX_W'(DEF_MOVE_COLOR),
    parameter logic [PIX_W-1:0] BACK_COLOR = PIX_W'(DEF_BACK_COLOR),
    parameter logic [PIX_W-1:0] FLASH_COLOR = PIX_W'(DEF_FLASH_COLOR),
    parameter int FLASH_FRAMES = 8
`ifdef GRID_LINES_EN
    ,
    parameter logic [PIX_W-1:0] LINE_COLOR = PIX_W'(DEF_LINE_COLOR)
`endif
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic [PIX_W-1:0]       qin,
    input  logic [COLS*ROWS-1:0]   background,
    input  logic [COLS*ROWS-1:0]   moving,
    input  logic [ROWS-1:0]        clear_rows,
    input  logic                   clear_start,
    output logic                   flash_busy,
    output logic                   flash_done,
    output logic                   sync_err,
    output logic [PIX_W-1:0]       qout
);
    localparam int CIW = cell_idx_w(COLS, ROWS);
    localparam int FW = idx_w(FLASH_FRAMES + 1);

    logic [idx_w(COLS)-1:0] cx;
    logic [idx_w(ROWS)-1:0] cy;
    logic in_grid, locked, frame_start;
`ifdef GRID_LINES_EN
    logic on_line;
`endif
    logic [PIX_W-1:0] qin_d, color;
    logic [CIW-1:0] k;
    logic [ROWS-1:0] mask;
    logic [FW-1:0] frame_cnt;
    logic phase;
    flash_state_t state;

    scan_tracker #(
        .ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES), .CELL_W(CELL_W),
        .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS), .X_OFF(X_OFF)
    ) u_scan (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .cx(cx),
        .cy(cy),
        .in_grid(in_grid),
        .locked(locked),
        .frame_start(frame_start),
`ifdef GRID_LINES_EN
        .on_line(on_line),
`endif
        .sync_err(sync_err)
    );

    assign k = CIW'(int'(cy) * COLS + int'(cx));
    assign color = !(locked && in_grid) ? qin_d
                 : flash_busy && phase && mask[cy] ? FLASH_COLOR
`ifdef GRID_LINES_EN
                 : on_line ? LINE_COLOR
`endif
                 : moving[k] ? MOVE_COLOR
                 : background[k] ? BACK_COLOR
                 : qin_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qin_d <= '0;
            qout <= '0;
        end else begin
            qin_d <= qin;
            qout <= color;
        end
    end

    // A start request in IDLE wins over a coincident frame start, which is then not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mask <= '0;
            frame_cnt <= '0;
            phase <= 1'b0;
            flash_busy <= 1'b0;
            flash_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (clear_start && |clear_rows) begin
                    state <= FLASH;
                    mask <= clear_rows;
                    frame_cnt <= '0;
                    phase <= 1'b1;
                    flash_busy <= 1'b1;
                end
                FLASH: if (frame_start) begin
                    phase <= !phase;
                    frame_cnt <= frame_cnt + 1'b1;
                    if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
                        state <= DONE;
                        flash_busy <= 1'b0;
                        flash_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flash_done <= 1'b0;
                    mask <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_grid_overlay_renderer.sv
// tb_grid_overlay_renderer: directed frame scans with a due-cycle scoreboard checked by a separate monitor.
module tb_grid_overlay_renderer;
    localparam int H = 96, V = 88, CW = 40, CH = 40, NC = 2, NR = 2, LAST = H * V - 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [18:0] address = '0;
    logic [7:0] qin = '0;
    logic [NC*NR-1:0] background = '0, moving = '0;
    logic [NR-1:0] clear_rows = '0;
    logic clear_start = 1'b0;
    logic flash_busy, flash_done, sync_err;
    logic [7:0] qout;

    grid_overlay_renderer #(
        .H_RES(H), .V_RES(V), .CELL_W(CW), .CELL_H(CH),
        .COLS(NC), .ROWS(NR), .FLASH_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .qin(qin),
        .background(background), .moving(moving), .clear_rows(clear_rows),
        .clear_start(clear_start), .flash_busy(flash_busy), .flash_done(flash_done),
        .sync_err(sync_err), .qout(qout)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int kind; int tag; logic [7:0] exp;} item_t;
    item_t sb[$];
    string kn[4] = '{"qout", "sync_err", "flash_done", "flash_busy"};
    int cyc = 0, total = 0, bad = 0, dc = 0;
    bit lk = 1'b0, fl_on = 1'b0;
    logic [NR-1:0] fl_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each cycle compare every expectation whose due cycle has arrived.
    always @(posedge clk) begin
        logic [7:0] act;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                act = sb[i].kind == 0 ? qout : sb[i].kind == 1 ? {7'd0, sync_err}
                    : sb[i].kind == 2 ? {7'd0, flash_done} : {7'd0, flash_busy};
                total++;
                if (act !== sb[i].exp || sb[i].due != cyc) begin
                    bad++;
                    $display("FAIL %s tag=%0d got=%h want=%h", kn[sb[i].kind], sb[i].tag, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic [7:0] qv(input int a);
        logic [7:0] t;
        t = a[7:0];
        return t ^ 8'h3C;
    endfunction

    function automatic logic [7:0] exp_pix(input int a);
        int x, y, k;
        x = a % H;
        y = a / H;
        if (!lk || x >= NC * CW || y >= NR * CH) return qv(a);
        k = (y / CH) * NC + x / CW;
        if (fl_on && fl_mask[y / CH]) return 8'hFF;
`ifdef GRID_LINES_EN
        if (x % CW == 0 || y % CH == 0) return 8'h11;
`endif
        if (moving[k]) return 8'hAA;
        if (background[k]) return 8'h55;
        return qv(a);
    endfunction

    function automatic bit sampled(input int a);
        int x, y;
        x = a % H;
        y = a / H;
        return ((x inside {0, 5, 39, 40, 41, 79, 80, 95}) && (y inside {0, 5, 39, 40, 41, 79, 80, 87})) || a % 25 == 0;
    endfunction

    task automatic push(input int k, input logic [7:0] e, input int tag);
        item_t it;
        it.due = dc + (k == 0 ? 2 : 1);
        it.kind = k;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic px(input int a, input bit cs = 1'b0, input logic [NR-1:0] cr = '0);
        @(negedge clk);
        address = 19'(a);
        qin = qv(a);
        clear_start = cs;
        clear_rows = cr;
        dc = cyc;
        if (sampled(a)) push(0, exp_pix(a), a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        dc = cyc;
        push(0, 8'h00, -1);
        push(1, 8'h00, -1);
        push(2, 8'h00, -1);
        push(3, 8'h00, -1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // Frame A: only cell 0 settled; an empty clear request is ignored.
        lk = 1'b1;
        background = 4'b0001;
        for (int a = 0; a <= LAST; a++) begin
            px(a, a == 300, '0);
            if (a == 300) push(3, 8'h00, a);
        end
        // Frame B: cell 3 both moving and settled, moving wins.
        background = 4'b1001;
        moving = 4'b1000;
        for (int a = 0; a <= LAST; a++) px(a);
        // Frame C: address jump drops lock until the next address 0.
        background = 4'b1111;
        moving = 4'b0000;
        for (int a = 0; a <= 1000; a++) px(a);
        lk = 1'b0;
        px(5000);
        push(1, 8'h01, 5000);
        for (int a = 5001; a <= 5101; a++) begin
            px(a);
            if (a < 5004 || a == 5101) push(1, 8'h00, a);
        end
        // Frame D: relock, with a 5-cycle stall at address 700.
        lk = 1'b1;
        background = 4'b0111;
        moving = 4'b0001;
        for (int a = 0; a <= LAST; a++) begin
            px(a);
            if (a == 700) begin
                for (int r = 0; r < 5; r++) begin
                    px(700);
                    push(1, 8'h00, 700);
                end
            end
        end
        // Frame E: flash row 0 starting together with the frame start.
        background = 4'b0001;
        moving = 4'b0000;
        fl_on = 1'b1;
        fl_mask = 2'b01;
        px(0, 1'b1, 2'b01);
        push(3, 8'h01, 0);
        for (int a = 1; a <= LAST; a++) begin
            px(a, a == 4000, 2'b10);
            if (a == 4000) push(3, 8'h01, a);
        end
        // Frame F: off-phase, still busy.
        fl_on = 1'b0;
        px(0);
        push(3, 8'h01, 0);
        push(2, 8'h00, 0);
        for (int a = 1; a <= LAST; a++) px(a);
        // Frame G: second frame start ends the flash.
        px(0);
        push(2, 8'h01, 0);
        push(3, 8'h00, 0);
        px(1);
        push(2, 8'h00, 1);
        for (int a = 2; a <= 2000; a++) px(a);
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
